// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
// Detects data hazards between the instruction in D and older instructions,
// issues stalls/bubbles, squashes on taken branches, and drains the pipeline
// after a halt. All state changes on the falling edge of CLK.
// Build option: define FORWARD_EN to enable M/W operand forwarding, in which
// case only load-use pairs stall; otherwise any pending write in E or M stalls.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic        Rs1Used_D,
  input  logic        Rs2Used_D,
  input  logic [4:0]  Rs1_E,
  input  logic [4:0]  Rs2_E,
  input  logic [4:0]  Rdst_E,
  input  logic [4:0]  Rdst_M,
  input  logic [4:0]  Rdst_W,
  input  logic        RegWrEn_E,
  input  logic        RegWrEn_M,
  input  logic        RegWrEn_W,
  input  logic        IsLoad_E,
  input  logic        BranchTaken_E,
  input  logic        halt_D,
  output logic        stall_F,
  output logic        stall_D,
  output logic        nop_D,
  output logic        nop_E,
  output logic        nop_M,
  output logic [1:0]  FwdA_E,
  output logic [1:0]  FwdB_E,
  output logic        Halted,
  output logic [15:0] StallCnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  drain_cnt_reg, drain_cnt_next;
  logic [15:0] stall_cnt_reg, stall_cnt_next;

  // Register r is produced by a stage when that stage writes (enable is
  // active-low) to the same non-zero register and r is really read.
  function automatic logic reg_match(input logic [4:0] r, input logic used,
                                     input logic [4:0] rd, input logic wr_en_n);
    return used && (r != 5'd0) && (r == rd) && !wr_en_n;
  endfunction

  logic [4:0] rs_d [2];
  logic       used_d [2];
  logic [1:0] hz_e;
  logic [1:0] hz_m;
  logic [1:0] fwd_sel [2];
  logic       data_hazard;

  assign rs_d[0]   = Rs1_D;
  assign rs_d[1]   = Rs2_D;
  assign used_d[0] = Rs1Used_D;
  assign used_d[1] = Rs2Used_D;

`ifdef FORWARD_EN
  logic [4:0] rs_e [2];
  assign rs_e[0] = Rs1_E;
  assign rs_e[1] = Rs2_E;
`else
  // Forwarding paths are absent in this build; these inputs are ignored.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Rs1_E, Rs2_E, Rdst_W, RegWrEn_W, IsLoad_E};
`endif

  // Per-operand hazard detection and forwarding select
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign hz_e[gi] = reg_match(rs_d[gi], used_d[gi], Rdst_E, RegWrEn_E);
    assign hz_m[gi] = reg_match(rs_d[gi], used_d[gi], Rdst_M, RegWrEn_M);
`ifdef FORWARD_EN
    // M holds the younger result, so it wins over W.
    assign fwd_sel[gi] = reg_match(rs_e[gi], 1'b1, Rdst_M, RegWrEn_M) ? 2'b01 :
                         reg_match(rs_e[gi], 1'b1, Rdst_W, RegWrEn_W) ? 2'b10 :
                                                                         2'b00;
`else
    assign fwd_sel[gi] = 2'b00;
`endif
  end

`ifdef FORWARD_EN
  // Only a load in E cannot be forwarded in time.
  assign data_hazard = IsLoad_E && (|hz_e);
  logic unused_hz_m;
  assign unused_hz_m = ^hz_m;
`else
  // Regfile writes before reads, so W never needs a stall.
  assign data_hazard = (|hz_e) || (|hz_m);
`endif

  // State register: control state, drain counter and stall statistics
  always_ff @(negedge CLK) begin
    if (!RST) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= 2'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Next-state logic: branch squashes everything, then data hazard, then halt
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    stall_cnt_next = stall_cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (BranchTaken_E) begin
          state_next = ST_RUN;
        end else if (data_hazard) begin
          if (stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
          end
        end else if (halt_D) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = 2'd3;
        end
      end
      ST_DRAIN: begin
        // Counter reaches 0 as we leave, giving exactly three drain cycles.
        if (drain_cnt_reg <= 2'd1) begin
          drain_cnt_next = 2'd0;
          state_next     = ST_HALTED;
        end else begin
          drain_cnt_next = drain_cnt_reg - 2'd1;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next     = ST_RUN;
        drain_cnt_next = 2'd0;
      end
    endcase
  end

  // Output logic: stall/bubble controls, all forced low while reset is held
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    nop_D   = 1'b0;
    nop_E   = 1'b0;
    nop_M   = 1'b0;
    FwdA_E  = 2'b00;
    FwdB_E  = 2'b00;
    if (RST) begin
      FwdA_E = fwd_sel[0];
      FwdB_E = fwd_sel[1];
      case (state_reg)
        ST_RUN: begin
          if (BranchTaken_E) begin
            nop_D = 1'b1;
            nop_E = 1'b1;
          end else if (data_hazard) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            nop_E   = 1'b1;
          end
        end
        ST_DRAIN: begin
          stall_F = 1'b1;
          nop_D   = 1'b1;
        end
        ST_HALTED: begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          nop_E   = 1'b1;
          nop_M   = 1'b1;
        end
        default: begin
          stall_F = 1'b0;
        end
      endcase
    end
  end

  assign Halted   = (state_reg == ST_HALTED);
  assign StallCnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. A behavioural model
// (drain countdown, halted flag, saturating counter) predicts every output on
// each rising edge; directed steps add literal expectations on top.
// Inputs change just after the falling (active) edge; checks run on the rising edge.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rdst_E, Rdst_M, Rdst_W;
  logic        Rs1Used_D, Rs2Used_D;
  logic        RegWrEn_E, RegWrEn_M, RegWrEn_W;
  logic        IsLoad_E, BranchTaken_E, halt_D;
  logic        stall_F, stall_D, nop_D, nop_E, nop_M, Halted;
  logic [1:0]  FwdA_E, FwdB_E;
  logic [15:0] StallCnt;

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1Used_D(Rs1Used_D), .Rs2Used_D(Rs2Used_D),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rdst_E(Rdst_E), .Rdst_M(Rdst_M), .Rdst_W(Rdst_W),
    .RegWrEn_E(RegWrEn_E), .RegWrEn_M(RegWrEn_M), .RegWrEn_W(RegWrEn_W),
    .IsLoad_E(IsLoad_E), .BranchTaken_E(BranchTaken_E), .halt_D(halt_D),
    .stall_F(stall_F), .stall_D(stall_D), .nop_D(nop_D), .nop_E(nop_E), .nop_M(nop_M),
    .FwdA_E(FwdA_E), .FwdB_E(FwdB_E), .Halted(Halted), .StallCnt(StallCnt)
  );

  // Output vector layout: {stall_F, stall_D, nop_D, nop_E, nop_M, FwdA[1:0], FwdB[1:0], Halted}
  localparam logic [9:0] ALL     = 10'h3FF;
  localparam logic [9:0] V_STALL = 10'b11_0_1_0_00_00_0;
  localparam logic [9:0] V_BR    = 10'b00_1_1_0_00_00_0;
  localparam logic [9:0] V_DRAIN = 10'b10_1_0_0_00_00_0;
  localparam logic [9:0] V_HALT  = 10'b11_0_1_1_00_00_1;
  localparam logic [9:0] M_FWDB  = 10'b00_0_0_0_00_11_0;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state (applied at the falling edge) and its pending next value
  bit m_valid = 0, nx_valid = 0;
  bit m_halted = 0, nx_halted = 0;
  int m_drain = 0, nx_drain = 0;
  int m_cnt = 0, nx_cnt = 0;

  // Literal expectations posted by the directed driver
  bit          lit_en = 0, lit_cnt_en = 0;
  string       lit_name = "";
  logic [9:0]  lit_mask = '0, lit_val = '0;
  logic [15:0] lit_cnt = '0;

  function automatic bit produces(logic [4:0] r, logic used, logic [4:0] rd, logic wen_n);
    return used && (r != 0) && (r == rd) && (wen_n == 1'b0);
  endfunction

  function automatic bit model_hazard();
`ifdef FORWARD_EN
    return IsLoad_E && (produces(Rs1_D, Rs1Used_D, Rdst_E, RegWrEn_E) ||
                        produces(Rs2_D, Rs2Used_D, Rdst_E, RegWrEn_E));
`else
    return produces(Rs1_D, Rs1Used_D, Rdst_E, RegWrEn_E) ||
           produces(Rs2_D, Rs2Used_D, Rdst_E, RegWrEn_E) ||
           produces(Rs1_D, Rs1Used_D, Rdst_M, RegWrEn_M) ||
           produces(Rs2_D, Rs2Used_D, Rdst_M, RegWrEn_M);
`endif
  endfunction

  function automatic logic [1:0] model_fwd(logic [4:0] r);
`ifdef FORWARD_EN
    if (produces(r, 1'b1, Rdst_M, RegWrEn_M)) return 2'b01;
    if (produces(r, 1'b1, Rdst_W, RegWrEn_W)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  logic [9:0] got_v, exp_v;
  logic [1:0] fa, fb;
  bit         hz;

  // Compare process: model check every cycle, plus any posted literal check
  always @(posedge CLK) begin
    got_v = {stall_F, stall_D, nop_D, nop_E, nop_M, FwdA_E, FwdB_E, Halted};
    hz = model_hazard();
    fa = model_fwd(Rs1_E);
    fb = model_fwd(Rs2_E);
    if (m_valid) begin
      if (!RST)                exp_v = {9'b0, m_halted};
      else if (m_halted)       exp_v = {5'b11011, fa, fb, 1'b1};
      else if (m_drain > 0)    exp_v = {5'b10100, fa, fb, 1'b0};
      else if (BranchTaken_E)  exp_v = {5'b00110, fa, fb, 1'b0};
      else if (hz)             exp_v = {5'b11010, fa, fb, 1'b0};
      else                     exp_v = {5'b00000, fa, fb, 1'b0};
      n_assert++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_outputs @%0t: got %b want %b", $time, got_v, exp_v);
      end
      n_assert++;
      if (StallCnt !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL model_stallcnt @%0t: got %h want %h", $time, StallCnt, 16'(m_cnt));
      end
    end
    if (lit_en) begin
      n_assert++;
      if ((got_v & lit_mask) !== (lit_val & lit_mask)) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (mask %b)", lit_name, got_v, lit_val, lit_mask);
      end
    end
    if (lit_cnt_en) begin
      n_assert++;
      if (StallCnt !== lit_cnt) begin
        n_fail++;
        $display("FAIL %s_stallcnt: got %h want %h", lit_name, StallCnt, lit_cnt);
      end
    end
    // Predict the state after the coming falling edge
    nx_valid = m_valid || (RST == 1'b0);
    if (!RST) begin
      nx_halted = 0; nx_drain = 0; nx_cnt = 0;
    end else begin
      nx_halted = m_halted; nx_drain = m_drain; nx_cnt = m_cnt;
      if (m_halted) begin
        nx_halted = 1;
      end else if (m_drain > 0) begin
        nx_drain = m_drain - 1;
        if (nx_drain == 0) nx_halted = 1;
      end else if (BranchTaken_E) begin
        nx_drain = 0;
      end else if (hz) begin
        nx_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else if (halt_D) begin
        nx_drain = 3;
      end
    end
  end

  always @(negedge CLK) begin
    m_valid  = nx_valid;
    m_halted = nx_halted;
    m_drain  = nx_drain;
    m_cnt    = nx_cnt;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
    lit_en = 0;
    lit_cnt_en = 0;
  endtask

  task automatic expect_out(input string nm, input logic [9:0] mask, input logic [9:0] val);
    lit_name = nm; lit_mask = mask; lit_val = val; lit_en = 1;
  endtask

  task automatic expect_cnt(input string nm, input logic [15:0] v);
    lit_name = nm; lit_cnt = v; lit_cnt_en = 1;
  endtask

  task automatic idle();
    Rs1_D = 0; Rs2_D = 0; Rs1Used_D = 0; Rs2Used_D = 0;
    Rs1_E = 0; Rs2_E = 0; Rdst_E = 0; Rdst_M = 0; Rdst_W = 0;
    RegWrEn_E = 1; RegWrEn_M = 1; RegWrEn_W = 1;
    IsLoad_E = 0; BranchTaken_E = 0; halt_D = 0;
  endtask

  task automatic set_hazard();
    idle();
`ifdef FORWARD_EN
    IsLoad_E = 1; Rdst_E = 5; RegWrEn_E = 0; Rs1_D = 5; Rs1Used_D = 1;
`else
    Rdst_M = 3; RegWrEn_M = 0; Rs2_D = 3; Rs2Used_D = 1;
`endif
  endtask

  function automatic logic [9:0] fwdb_vec(logic [1:0] f);
    return {7'b0, f, 1'b0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    RST = 0;
    tick();
    expect_out("reset_outputs", ALL, 10'b0);
    expect_cnt("reset_outputs", 16'h0000);
    tick();
    RST = 1;

    // Data hazard stalls one cycle and counts
    set_hazard();
    expect_out("stall_on_hazard", ALL, V_STALL);
    expect_cnt("stall_on_hazard", 16'h0000);
    tick();
`ifdef FORWARD_EN
    idle();
`else
    RegWrEn_M = 1;
`endif
    expect_out("no_stall_after", ALL, 10'b0);
    expect_cnt("no_stall_after", 16'h0001);
    tick();

    // Forwarding selects on operand B
    idle();
    Rs2_E = 7; Rdst_M = 7; Rdst_W = 7; RegWrEn_M = 0; RegWrEn_W = 0;
`ifdef FORWARD_EN
    expect_out("fwdb_from_m", M_FWDB, fwdb_vec(2'b01));
`else
    expect_out("fwdb_const_m", M_FWDB, fwdb_vec(2'b00));
`endif
    tick();
    Rdst_M = 0;
`ifdef FORWARD_EN
    expect_out("fwdb_from_w", M_FWDB, fwdb_vec(2'b10));
`else
    expect_out("fwdb_const_w", M_FWDB, fwdb_vec(2'b00));
`endif
    tick();
    Rs2_E = 0;
    expect_out("fwdb_x0", M_FWDB, fwdb_vec(2'b00));
    tick();

    // Reset in the middle of a drain
    idle();
    halt_D = 1;
    expect_out("halt_in_run", ALL, 10'b0);
    tick();
    halt_D = 0;
    expect_out("drain_before_reset", ALL, V_DRAIN);
    tick();
    RST = 0;
    expect_out("reset_in_drain", ALL, 10'b0);
    tick();
    RST = 1;
    expect_out("after_drain_reset", ALL, 10'b0);
    expect_cnt("after_drain_reset", 16'h0000);
    tick();

    // Branch squashes a halt
    BranchTaken_E = 1; halt_D = 1;
    expect_out("branch_with_halt", ALL, V_BR);
    tick();
    idle();
    expect_out("halt_squashed", ALL, 10'b0);
    tick();

    // Full halt sequence: three drain cycles then held in HALTED
    halt_D = 1;
    tick();
    halt_D = 0;
    for (int i = 0; i < 3; i++) begin
      expect_out("drain_cycle", ALL, V_DRAIN);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      BranchTaken_E = (i == 2);
      expect_out("halted_hold", ALL, V_HALT);
      tick();
    end
    idle();
    RST = 0;
    expect_out("reset_while_halted", ALL & ~10'b1, 10'b0);
    tick();
    RST = 1;
    expect_out("after_halt_reset", ALL, 10'b0);
    tick();

    // Randomized traffic, small register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      Rdst_E = 5'($urandom_range(0, 3)); Rdst_M = 5'($urandom_range(0, 3));
      Rdst_W = 5'($urandom_range(0, 3));
      Rs1Used_D = 1'($urandom_range(0, 1)); Rs2Used_D = 1'($urandom_range(0, 1));
      RegWrEn_E = 1'($urandom_range(0, 1)); RegWrEn_M = 1'($urandom_range(0, 1));
      RegWrEn_W = 1'($urandom_range(0, 1)); IsLoad_E = 1'($urandom_range(0, 1));
      BranchTaken_E = ($urandom_range(0, 7) == 0);
      halt_D = ($urandom_range(0, 49) == 0);
      RST = ($urandom_range(0, 39) != 0);
      tick();
    end

    // StallCnt saturation
    idle();
    RST = 0;
    tick();
    RST = 1;
    set_hazard();
    for (int i = 0; i < 65534; i++) tick();
    expect_cnt("stallcnt_fffe", 16'hFFFE);
    tick();
    tick();
    tick();
    expect_cnt("stallcnt_saturated", 16'hFFFF);
    expect_out("stall_at_saturation", ALL, V_STALL);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  single clock; all state updates on falling edge.
REQ-002 SHALL have ports: RST  in  1  reset, synchronous, active-low, sampled on falling edge of CLK.
REQ-003 SHALL have ports: Rs1_D, Rs2_D  in  5 each  source regs of instruction in D.
REQ-004 SHALL have ports: Rs1Used_D, Rs2Used_D  in  1 each  source actually read.
REQ-005 SHALL have ports: Rs1_E, Rs2_E  in  5 each  source regs of instruction in E.
REQ-006 SHALL have ports: Rdst_E, Rdst_M, Rdst_W  in  5 each  destination regs.
REQ-007 SHALL have ports: RegWrEn_E, RegWrEn_M, RegWrEn_W  in  1 each  active-low write enable (0 = writes).
REQ-008 SHALL have ports: IsLoad_E  in  1  E instruction is a load.
REQ-009 SHALL have ports: BranchTaken_E  in  1  redirect resolved in E.
REQ-010 SHALL have ports: halt_D  in  1  halt instruction in D.
REQ-011 SHALL have ports: stall_F, stall_D  out  1 each  hold PC / IF_ID register.
REQ-012 SHALL have ports: nop_D, nop_E, nop_M  out  1 each  bubble into IF_ID / ID_EX / EX_MEM.
REQ-013 SHALL have ports: FwdA_E, FwdB_E  out  2 each  operand select: 00 regfile, 01 from M, 10 from W.
REQ-014 SHALL have ports: Halted  out  1  pipeline drained after halt.
REQ-015 SHALL have ports: StallCnt  out  16  data-hazard stall cycle count.

Function
REQ-016 SHALL keep state in {RUN, DRAIN, HALTED}; stall/nop/Fwd outputs combinational from inputs and state.
REQ-017 SHALL define hazard match on register r vs stage X: r != 0, RsNUsed_D = 1, r == Rdst_X, RegWrEn_X = 0.
REQ-018 SHALL, in RUN with BranchTaken_E = 1, assert nop_D = 1 and nop_E = 1; stall_F = stall_D = 0 (branch has highest priority).
REQ-019 SHALL, in RUN without branch, on data hazard (REQ-027/028), assert stall_F = stall_D = nop_E = 1.
REQ-020 SHALL, in RUN with halt_D = 1 and no branch or data hazard, go to DRAIN and load drain counter with 3.
REQ-021 SHALL, in DRAIN, assert stall_F = 1 and nop_D = 1 and decrement the drain counter each cycle; at counter 0 go to HALTED.
REQ-022 SHALL, in HALTED, assert stall_F = stall_D = nop_E = nop_M = 1 and Halted = 1; stay there until reset.
REQ-023 SHALL squash halt_D when BranchTaken_E = 1 in the same cycle (stay in RUN).
REQ-024 SHALL increment StallCnt by 1 each cycle REQ-019 applies; saturate at 16'hFFFF.
REQ-025 SHALL keep nop_M = 0 outside HALTED.

Reset
REQ-026 SHALL, while RST = 0 at a falling edge, set state RUN, drain counter 0, StallCnt 0, Halted 0; while RST = 0, force all stall/nop/Fwd outputs to 0; reset mid-DRAIN aborts drain.

Configuration
REQ-027 SHALL, with FORWARD_EN defined, flag data hazard only for load-use: IsLoad_E = 1 and match vs E; FwdA_E/FwdB_E select M (match vs M on Rs1_E/Rs2_E) over W (match vs W), else 00; x0 never forwards.
REQ-028 SHALL, without FORWARD_EN, flag data hazard on any match vs E or M (regfile writes before reads, so W never hazards); FwdA_E = FwdB_E = 00 constant.

Verification
REQ-029 SHALL bench: FORWARD_EN, IsLoad_E = 1, Rdst_E = 5, RegWrEn_E = 0, Rs1_D = 5, Rs1Used_D = 1 -> stall_F = stall_D = nop_E = 1 one cycle; StallCnt 0 -> 1.
REQ-030 SHALL bench: FORWARD_EN, Rs2_E = 7, Rdst_M = 7, Rdst_W = 7, both enables 0 -> FwdB_E = 01; Rdst_M = 0 instead -> FwdB_E = 10; Rs2_E = 0 -> 00.
REQ-031 SHALL bench: no FORWARD_EN, ALU op Rdst_M = 3, RegWrEn_M = 0, Rs2_D = 3 used -> stall asserted; same with RegWrEn_M = 1 -> no stall.
REQ-032 SHALL bench: halt_D = 1 in RUN -> DRAIN 3 cycles with stall_F = nop_D = 1, then Halted = 1 held; halt_D with BranchTaken_E = 1 -> nop_D = nop_E = 1, stays RUN.
REQ-033 SHALL bench: RST low in DRAIN -> next edge state RUN, Halted 0, StallCnt 0; StallCnt preloaded to 16'hFFFE plus 3 stall cycles -> 16'hFFFF.
